// File: rtl/soc_io_mini_pkg.sv
// Shared definitions for soc_io_mini: MIPS-subset encodings, the I/O map,
// pipeline stage records, the instruction decoder and the boot ROM image.
package soc_io_mini_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_ADDU = 6'h21;

  localparam logic [31:0] IO_OPR1_ADDR   = 32'h0000_8000;
  localparam logic [31:0] IO_OPR2_ADDR   = 32'h0000_8004;
  localparam logic [31:0] IO_RESULT_ADDR = 32'h0000_8008;

  typedef enum logic [1:0] {BR_NONE, BR_BEQ, BR_BNE, BR_J} br_kind_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       use_imm;
    logic       is_shift;
    logic [4:0] dst;
  } ctrl_t;

  typedef struct packed {
    ctrl_t    ctrl;
    br_kind_e br;
    logic     uses_rs;
    logic     uses_rt;
  } decode_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  shamt;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  dst;
    logic [31:0] alu_res;
    logic [31:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  dst;
    logic [31:0] data;
  } mem_wb_t;

  function automatic decode_t decode_instr(input logic [31:0] instr);
    decode_t d;
    d = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        if (instr[5:0] == FN_ADDU) begin
          d.ctrl.reg_write = 1'b1;
          d.ctrl.dst       = instr[15:11];
          d.uses_rs        = 1'b1;
          d.uses_rt        = 1'b1;
        end else if (instr[5:0] == FN_SLL) begin
          d.ctrl.reg_write = 1'b1;
          d.ctrl.is_shift  = 1'b1;
          d.ctrl.dst       = instr[15:11];
          d.uses_rt        = 1'b1;
        end
      end
      OP_ADDIU: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.use_imm   = 1'b1;
        d.ctrl.dst       = instr[20:16];
        d.uses_rs        = 1'b1;
      end
      OP_LW: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.mem_read  = 1'b1;
        d.ctrl.use_imm   = 1'b1;
        d.ctrl.dst       = instr[20:16];
        d.uses_rs        = 1'b1;
      end
      OP_SW: begin
        d.ctrl.mem_write = 1'b1;
        d.ctrl.use_imm   = 1'b1;
        d.uses_rs        = 1'b1;
        d.uses_rt        = 1'b1;
      end
      OP_BEQ: begin
        d.br      = BR_BEQ;
        d.uses_rs = 1'b1;
        d.uses_rt = 1'b1;
      end
      OP_BNE: begin
        d.br      = BR_BNE;
        d.uses_rs = 1'b1;
        d.uses_rt = 1'b1;
      end
      OP_J:    d.br = BR_J;
      default: ;
    endcase
    // Writes to r0 are dropped here, so hazard and forwarding logic never match on r0.
    if (d.ctrl.dst == 5'd0) d.ctrl.reg_write = 1'b0;
    return d;
  endfunction

  function automatic logic [31:0] rom_word(input logic [3:0] idx);
    case (idx)
      4'd0:    return 32'h240A_4000;  // addiu r10,r0,0x4000
      4'd1:    return 32'h000A_5040;  // sll   r10,r10,1
      4'd2:    return 32'h8D41_0000;  // loop: lw r1,0(r10)
      4'd3:    return 32'h8D42_0004;  // lw    r2,4(r10)
      4'd4:    return 32'h0000_1821;  // addu  r3,r0,r0
      4'd5:    return 32'h1040_0003;  // beq   r2,r0,done
      4'd6:    return 32'h0061_1821;  // mul:  addu r3,r3,r1
      4'd7:    return 32'h2442_FFFF;  // addiu r2,r2,-1
      4'd8:    return 32'h1440_FFFD;  // bne   r2,r0,mul
      4'd9:    return 32'hAD43_0008;  // done: sw r3,8(r10)
      4'd10:   return 32'h0800_0002;  // j     loop
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/soc_io_mini_mips_core.sv
// Five-stage MIPS-subset pipeline with EX forwarding, branch resolution in ID
// and the hazard unit; exposes an instruction bus and a data bus.
module mips_core
  import soc_io_mini_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we,
  input  logic [31:0] dmem_rdata
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  id_ex_t      id_ex_q, id_ex_d;
  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_wb_t     mem_wb_q, mem_wb_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  decode_t     dec;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] rs_rf, rt_rf, rs_br, rt_br, imm_sext, br_target;
  logic        is_branch, ex_hit, mem_hit, stall, taken;
  logic        load_branch_conflict;
  logic [31:0] ex_a, ex_b, alu_b, alu_res;

  assign imem_addr = pc_q;

  // ID: register read with write-through from WB, branch operands also forwarded from MEM.
  always_comb begin
    dec      = decode_instr(if_id_instr_q);
    id_rs    = if_id_instr_q[25:21];
    id_rt    = if_id_instr_q[20:16];
    imm_sext = {{16{if_id_instr_q[15]}}, if_id_instr_q[15:0]};
    rs_rf    = regs_q[id_rs];
    rt_rf    = regs_q[id_rt];
    if (mem_wb_q.reg_write && mem_wb_q.dst == id_rs) rs_rf = mem_wb_q.data;
    if (mem_wb_q.reg_write && mem_wb_q.dst == id_rt) rt_rf = mem_wb_q.data;
    rs_br = rs_rf;
    rt_br = rt_rf;
    if (ex_mem_q.reg_write && !ex_mem_q.mem_read && ex_mem_q.dst == id_rs) rs_br = ex_mem_q.alu_res;
    if (ex_mem_q.reg_write && !ex_mem_q.mem_read && ex_mem_q.dst == id_rt) rt_br = ex_mem_q.alu_res;
  end

  always_comb begin
    is_branch = (dec.br == BR_BEQ) || (dec.br == BR_BNE);
    ex_hit  = id_ex_q.ctrl.reg_write &&
              ((dec.uses_rs && id_ex_q.ctrl.dst == id_rs) || (dec.uses_rt && id_ex_q.ctrl.dst == id_rt));
    mem_hit = ex_mem_q.reg_write &&
              ((dec.uses_rs && ex_mem_q.dst == id_rs) || (dec.uses_rt && ex_mem_q.dst == id_rt));
    load_branch_conflict = is_branch &&
                           ((ex_hit && id_ex_q.ctrl.mem_read) || (mem_hit && ex_mem_q.mem_read));
    stall = load_branch_conflict || (ex_hit && (is_branch || id_ex_q.ctrl.mem_read));
    taken = !stall && ((dec.br == BR_J) ||
                       (dec.br == BR_BEQ && rs_br == rt_br) ||
                       (dec.br == BR_BNE && rs_br != rt_br));
    br_target = (dec.br == BR_J) ? {if_id_pc4_q[31:28], if_id_instr_q[25:0], 2'b00}
                                 : if_id_pc4_q + {imm_sext[29:0], 2'b00};
  end

  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    pc_d          = pc_q + 32'd4;
    if_id_instr_d = imem_rdata;
    if_id_pc4_d   = pc_q + 32'd4;
    id_ex_d        = '0;
    id_ex_d.ctrl   = dec.ctrl;
    id_ex_d.rs     = id_rs;
    id_ex_d.rt     = id_rt;
    id_ex_d.rs_val = rs_rf;
    id_ex_d.rt_val = rt_rf;
    id_ex_d.imm    = imm_sext;
    id_ex_d.shamt  = if_id_instr_q[10:6];
    if (stall) begin
      pc_d          = pc_q;
      if_id_instr_d = if_id_instr_q;
      if_id_pc4_d   = if_id_pc4_q;
      id_ex_d       = '0;
    end else if (taken) begin
      pc_d          = br_target;
      if_id_instr_d = '0;
    end
  end

  // EX: MEM result takes priority over WB when both target the same register.
  always_comb begin
    ex_a = id_ex_q.rs_val;
    ex_b = id_ex_q.rt_val;
    if (mem_wb_q.reg_write && mem_wb_q.dst == id_ex_q.rs) ex_a = mem_wb_q.data;
    if (mem_wb_q.reg_write && mem_wb_q.dst == id_ex_q.rt) ex_b = mem_wb_q.data;
    if (ex_mem_q.reg_write && !ex_mem_q.mem_read && ex_mem_q.dst == id_ex_q.rs) ex_a = ex_mem_q.alu_res;
    if (ex_mem_q.reg_write && !ex_mem_q.mem_read && ex_mem_q.dst == id_ex_q.rt) ex_b = ex_mem_q.alu_res;
    alu_b   = id_ex_q.ctrl.use_imm ? id_ex_q.imm : ex_b;
    alu_res = id_ex_q.ctrl.is_shift ? (ex_b << id_ex_q.shamt) : (ex_a + alu_b);
    ex_mem_d.reg_write  = id_ex_q.ctrl.reg_write;
    ex_mem_d.mem_read   = id_ex_q.ctrl.mem_read;
    ex_mem_d.mem_write  = id_ex_q.ctrl.mem_write;
    ex_mem_d.dst        = id_ex_q.ctrl.dst;
    ex_mem_d.alu_res    = alu_res;
    ex_mem_d.store_data = ex_b;
  end

  always_comb begin
    dmem_addr          = ex_mem_q.alu_res;
    dmem_wdata         = ex_mem_q.store_data;
    dmem_we            = ex_mem_q.mem_write;
    mem_wb_d.reg_write = ex_mem_q.reg_write;
    mem_wb_d.dst       = ex_mem_q.dst;
    mem_wb_d.data      = ex_mem_q.mem_read ? dmem_rdata : ex_mem_q.alu_res;
    regs_d = regs_q;
    if (mem_wb_q.reg_write) regs_d[mem_wb_q.dst] = mem_wb_q.data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= '0;
      if_id_instr_q <= '0;
      if_id_pc4_q   <= '0;
      id_ex_q       <= '0;
      ex_mem_q      <= '0;
      mem_wb_q      <= '0;
      // NOTE: the register file is architectural state and is cleared by reset; the data RAM is not.
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      id_ex_q       <= id_ex_d;
      ex_mem_q      <= ex_mem_d;
      mem_wb_q      <= mem_wb_d;
      regs_q        <= regs_d;
    end
  end

endmodule

// File: rtl/soc_io_mini.sv
// SoC top: pipeline core, 16-word boot ROM, 16-word data RAM and the
// memory-mapped operand inputs / result register.
module soc_io_mini
  import soc_io_mini_pkg::*;
(
  input  logic        base_clk,
  input  logic        reset,
  input  logic [7:0]  opr1,
  input  logic [7:0]  opr2,
  output logic [15:0] result
);

  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_we;
  logic        rom_hit, io_sel;
  logic [31:0] ram_q [16];
  logic [31:0] ram_d [16];
  logic [15:0] result_q, result_d;

  mips_core core0 (
    .clk        (base_clk),
    .rst_n      (reset),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata)
  );

  // Fetches outside the 16-word ROM window return a nop.
  always_comb begin
    rom_hit    = (imem_addr[31:6] == '0) && (imem_addr[1:0] == 2'b00);
    imem_rdata = rom_hit ? rom_word(imem_addr[5:2]) : '0;
  end

  always_comb begin
    io_sel     = dmem_addr[15];
    dmem_rdata = '0;
    if (!io_sel)                          dmem_rdata = ram_q[dmem_addr[5:2]];
    else if (dmem_addr == IO_OPR1_ADDR)   dmem_rdata = {24'd0, opr1};
    else if (dmem_addr == IO_OPR2_ADDR)   dmem_rdata = {24'd0, opr2};
  end

  always_comb begin
    ram_d    = ram_q;
    result_d = result_q;
    if (dmem_we) begin
      if (!io_sel)                            ram_d[dmem_addr[5:2]] = dmem_wdata;
      else if (dmem_addr == IO_RESULT_ADDR)   result_d = dmem_wdata[15:0];
    end
  end

  always_ff @(posedge base_clk) begin
    ram_q <= ram_d;
  end

  always_ff @(posedge base_clk or negedge reset) begin
    if (!reset) result_q <= '0;
    else        result_q <= result_d;
  end

  assign result = result_q;

endmodule

// File: tb/tb_soc_io_mini.sv
// Directed self-checking bench for soc_io_mini: runs the built-in multiply
// program over several operand pairs, mid-loop changes and a mid-loop reset.
module tb_soc_io_mini;

  logic        base_clk;
  logic        reset;
  logic [7:0]  opr1;
  logic [7:0]  opr2;
  logic [15:0] result;

  int checks   = 0;
  int failures = 0;

  soc_io_mini dut (
    .base_clk (base_clk),
    .reset    (reset),
    .opr1     (opr1),
    .opr2     (opr2),
    .result   (result)
  );

  initial base_clk = 1'b0;
  always #5 base_clk = ~base_clk;

  logic store_seen;
  assign store_seen = dut.core0.dmem_we && (dut.core0.dmem_addr == 32'h0000_8008);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for exp; meanwhile result may only hold old_val.
  task automatic wait_result(input logic [15:0] exp, input logic [15:0] old_val,
                             input int budget, input string tag);
    bit found;
    int stray;
    found = 1'b0;
    stray = 0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge base_clk);
      if (result === exp)          found = 1'b1;
      else if (result !== old_val) stray++;
    end
    check({tag, "_reached"}, {31'd0, found}, 32'd1);
    check({tag, "_no_stray_value"}, stray, 32'd0);
  endtask

  task automatic wait_store(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge base_clk);
      if (store_seen) seen = 1'b1;
    end
    check({tag, "_store_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic hold_stable(input logic [15:0] exp, input int cycles, input string tag);
    int bad;
    bad = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge base_clk);
      if (result !== exp) bad++;
    end
    check({tag, "_stable"}, bad, 32'd0);
  endtask

  // Counts conflict cycles between two consecutive result stores.
  task automatic measure_pass(input string tag);
    int stores;
    int conf;
    stores = 0;
    conf   = 0;
    for (int n = 0; n < 3000 && stores < 2; n++) begin
      @(negedge base_clk);
      if (store_seen) stores++;
      else if (stores == 1 && dut.core0.load_branch_conflict) conf++;
    end
    check({tag, "_two_stores"}, stores, 32'd2);
    check({tag, "_conflicts_per_pass"}, conf, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    opr1  = 8'd3;
    opr2  = 8'd15;
    repeat (3) @(negedge base_clk);
    check("reset_result", {16'd0, result}, 32'd0);
    check("reset_conflict", {31'd0, dut.core0.load_branch_conflict}, 32'd0);
    check("reset_pc", dut.core0.pc_q, 32'd0);

    reset = 1'b1;
    @(negedge base_clk);
    check("first_fetch_pc", dut.core0.pc_q, 32'd4);
    repeat (20) @(negedge base_clk);
    check("result_zero_before_store", {16'd0, result}, 32'd0);
    wait_result(16'd45, 16'd0, 100, "mul_3x15");
    hold_stable(16'd45, 100, "mul_3x15");
    measure_pass("pass_3x15");

    wait_store("midloop");
    repeat (30) @(negedge base_clk);
    opr1 = 8'd4;
    opr2 = 8'd4;
    wait_result(16'd16, 16'd45, 200, "midloop_4x4");

    wait_store("big");
    opr1 = 8'd255;
    opr2 = 8'd255;
    wait_result(16'hFE01, 16'd16, 1500, "mul_255x255");

    wait_store("zero");
    opr1 = 8'd7;
    opr2 = 8'd0;
    wait_result(16'd0, 16'hFE01, 100, "zero_opr2");
    hold_stable(16'd0, 60, "zero_opr2");
    measure_pass("pass_zero");

    wait_store("restore");
    opr1 = 8'd3;
    opr2 = 8'd15;
    wait_result(16'd45, 16'd0, 150, "restore_3x15");

    wait_store("midreset");
    repeat (30) @(negedge base_clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_result", {16'd0, result}, 32'd0);
    check("async_reset_pc", dut.core0.pc_q, 32'd0);
    check("async_reset_r3", dut.core0.regs_q[3], 32'd0);
    repeat (3) @(negedge base_clk);
    reset = 1'b1;
    wait_result(16'd45, 16'd0, 120, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
